// File: rtl/mainsource_arbiter.sv
// mainsource_arbiter
// Round-robin sequencer for the shared combinational source unit (MainSource).
// Two requesters hand over an operand/flag pair with a valid/ready handshake.
// The winner's operands are registered onto src_x_in/src_flag for one full
// ISSUE cycle. The unit's y_out is then captured and returned with the owner's
// id on a valid/ready response channel.
//
// Handshake semantics (all channels): a transfer happens on a rising CLK edge
// where valid and ready are both high. A requester keeps valid/x/flag stable
// until it sees ready. The arbiter holds rsp_valid/rsp_id/rsp_data stable until
// rsp_ready is seen.
//
// Ports:
//   CLK, Reset                 clock (rising edge), async active-low reset
//   req{0,1}_valid/_x/_flag    requester operation
//   req{0,1}_ready             combinational grant, high only in IDLE for the winner
//   src_x_in, src_flag         registered drive into the shared unit
//   src_y_out                  shared unit result (combinational from src_*)
//   rsp_valid/_id/_data        response channel, rsp_ready from consumer
//   busy                       high whenever the FSM is not IDLE
//   op_count                   completed responses, wraps 255 -> 0
//   state_dbg                  current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
module mainsource_arbiter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_x,
    input  logic         req0_flag,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_x,
    input  logic         req1_flag,
    output logic         req1_ready,
    output logic [W-1:0] src_x_in,
    output logic         src_flag,
    input  logic [W-1:0] src_y_out,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    input  logic         rsp_ready,
    output logic         busy,
    output logic [7:0]   op_count,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   last_grant;
    logic   pick1;
    logic   accept;
    logic   rsp_fire;

    // Requester 1 wins when it is the only one asking, or on a tie when
    // requester 0 was served last. Every other case with a request goes to 0.
    assign pick1 = req1_valid & (~req0_valid | ~last_grant);

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    accept     = 1'b1;
                    req1_ready = pick1;
                    req0_ready = ~pick1;
                    state_nx   = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_fire = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            src_x_in   <= '0;
            src_flag   <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            op_count   <= 8'd0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nx;
            if (accept) begin
                src_x_in <= pick1 ? req1_x : req0_x;
                src_flag <= pick1 ? req1_flag : req0_flag;
                rsp_id   <= pick1;
            end
            // Operands have been stable at the unit for the whole ISSUE cycle.
            if (state == ISSUE) begin
                rsp_data <= src_y_out;
            end
            if (rsp_fire) begin
                op_count   <= op_count + 8'd1;
                last_grant <= rsp_id;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
